// File: rtl/module_sevenseg_scan_if.sv
// ---------------------------------------------------------------------------
// module_sevenseg_scan_if : datapath-side load port and display-pin bundle
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface module_sevenseg_scan_if #(
    parameter int NUM_DIGITS = 4
);
    logic [4*NUM_DIGITS-1:0] data;
    logic [NUM_DIGITS-1:0]   dp_in;
    logic [NUM_DIGITS-1:0]   blank_in;
    logic                    lz_en;
    logic                    load;
    logic [6:0]              seg;
    logic                    dp;
    logic [NUM_DIGITS-1:0]   an;
    logic                    frame_done;

    modport master (
        output data, dp_in, blank_in, lz_en, load,
        input  seg, dp, an, frame_done
    );

    modport slave (
        input  data, dp_in, blank_in, lz_en, load,
        output seg, dp, an, frame_done
    );
endinterface

`default_nettype wire

// File: rtl/module_sevenseg_scan.sv
// ---------------------------------------------------------------------------
// module_sevenseg_scan : multiplexed N-digit seven-segment driver, frame-synced
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module module_sevenseg_scan #(
    parameter int NUM_DIGITS     = 4,
    parameter int SCAN_DIV       = 27000,
    parameter int BLANK_CYCLES   = 1,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit AN_ACTIVE_LOW  = 1'b1
) (
    input  wire logic               clk,
    input  wire logic               rst_n,
    module_sevenseg_scan_if.slave   bus
);

    localparam int c_CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int c_IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(SCAN_DIV - 1);
    localparam logic [c_IDX_W-1:0] c_IDX_MAX = c_IDX_W'(NUM_DIGITS - 1);
    localparam logic [c_CNT_W-1:0] c_BLANK   = c_CNT_W'(BLANK_CYCLES);

    logic [c_CNT_W-1:0]      r_cnt;
    logic [c_IDX_W-1:0]      r_idx;

    logic [4*NUM_DIGITS-1:0] r_act_data;
    logic [NUM_DIGITS-1:0]   r_act_dp;
    logic [NUM_DIGITS-1:0]   r_act_blank;
    logic                    r_act_lz;

    logic [4*NUM_DIGITS-1:0] r_pend_data;
    logic [NUM_DIGITS-1:0]   r_pend_dp;
    logic [NUM_DIGITS-1:0]   r_pend_blank;
    logic                    r_pend_lz;
    logic                    r_pend_valid;

    logic [6:0]              r_seg;
    logic                    r_dp;
    logic [NUM_DIGITS-1:0]   r_an;
    logic                    r_frame_done;

    logic                    w_slot_end;
    logic                    w_boundary;
    logic [3:0]              w_nib;
    logic                    w_dp_sel;
    logic                    w_blank_sel;
    logic                    w_suppress;
    logic                    w_zero_above;
    logic                    w_an_on;
    logic [NUM_DIGITS-1:0]   w_an_log;
    logic [6:0]              w_seg_log;
    logic                    w_dp_log;

    function automatic logic [6:0] f_decode(input logic [3:0] nib);
        logic [6:0] v;
        case (nib)
            4'h0: v = 7'b0111111;
            4'h1: v = 7'b0000110;
            4'h2: v = 7'b1011011;
            4'h3: v = 7'b1001111;
            4'h4: v = 7'b1100110;
            4'h5: v = 7'b1101101;
            4'h6: v = 7'b1111101;
            4'h7: v = 7'b0000111;
            4'h8: v = 7'b1111111;
            4'h9: v = 7'b1101111;
            4'hA: v = 7'b1110111;
            4'hB: v = 7'b1111100;
            4'hC: v = 7'b0111001;
            4'hD: v = 7'b1011110;
            4'hE: v = 7'b1111001;
            default: v = 7'b1110001;
        endcase
        return v;
    endfunction

    assign w_slot_end = (r_cnt == c_CNT_MAX);
    assign w_boundary = w_slot_end && (r_idx == c_IDX_MAX);

    // Walk digits from the top down so the "all higher nibbles zero" flag
    // is already accumulated when the current digit is reached.
    always_comb begin
        w_nib        = 4'h0;
        w_dp_sel     = 1'b0;
        w_blank_sel  = 1'b0;
        w_suppress   = 1'b0;
        w_zero_above = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            w_zero_above = w_zero_above && (r_act_data[4*i +: 4] == 4'h0);
            if (r_idx == c_IDX_W'(i)) begin
                w_nib       = r_act_data[4*i +: 4];
                w_dp_sel    = r_act_dp[i];
                w_blank_sel = r_act_blank[i];
                w_suppress  = r_act_lz && (i != 0) && w_zero_above;
            end
        end
    end

    always_comb begin
        w_an_on   = (r_cnt >= c_BLANK) && !w_blank_sel;
        w_an_log  = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            w_an_log[i] = w_an_on && (r_idx == c_IDX_W'(i));
        end
        w_seg_log = (w_an_on && !w_suppress) ? f_decode(w_nib) : 7'h00;
        w_dp_log  = w_an_on && w_dp_sel;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt        <= '0;
            r_idx        <= '0;
            r_act_data   <= '0;
            r_act_dp     <= '0;
            r_act_blank  <= '0;
            r_act_lz     <= 1'b0;
            r_pend_data  <= '0;
            r_pend_dp    <= '0;
            r_pend_blank <= '0;
            r_pend_lz    <= 1'b0;
            r_pend_valid <= 1'b0;
            r_seg        <= {7{SEG_ACTIVE_LOW}};
            r_dp         <= SEG_ACTIVE_LOW;
            r_an         <= {NUM_DIGITS{AN_ACTIVE_LOW}};
            r_frame_done <= 1'b0;
        end else begin
            r_cnt <= w_slot_end ? '0 : r_cnt + c_CNT_W'(1);
            if (w_slot_end) begin
                r_idx <= (r_idx == c_IDX_MAX) ? '0 : r_idx + c_IDX_W'(1);
            end

            if (w_boundary && r_pend_valid) begin
                r_act_data  <= r_pend_data;
                r_act_dp    <= r_pend_dp;
                r_act_blank <= r_pend_blank;
                r_act_lz    <= r_pend_lz;
            end

            // A load on the boundary cycle refills pending after the copy.
            if (bus.load) begin
                r_pend_data  <= bus.data;
                r_pend_dp    <= bus.dp_in;
                r_pend_blank <= bus.blank_in;
                r_pend_lz    <= bus.lz_en;
                r_pend_valid <= 1'b1;
            end else if (w_boundary) begin
                r_pend_valid <= 1'b0;
            end

            r_seg        <= w_seg_log ^ {7{SEG_ACTIVE_LOW}};
            r_dp         <= w_dp_log ^ SEG_ACTIVE_LOW;
            r_an         <= w_an_log ^ {NUM_DIGITS{AN_ACTIVE_LOW}};
            r_frame_done <= w_boundary;
        end
    end

    assign bus.seg        = r_seg;
    assign bus.dp         = r_dp;
    assign bus.an         = r_an;
    assign bus.frame_done = r_frame_done;

endmodule

`default_nettype wire

// File: doc/module_sevenseg_scan.md
# module_sevenseg_scan

Parametrised, time-multiplexed N-digit seven-segment display driver. It latches a packed hex word plus per-digit decimal-point and blank masks, then scans one digit at a time onto a shared segment bus with one-hot anode select. Each digit is decoded with the team's standard hex-to-segment map for 0–F. Sits between the datapath (counters, results) and the board display pins. Adds tear-free frame-synchronous updates, leading-zero suppression, inter-digit ghost blanking and selectable output polarity.

## Interface
- NUM_DIGITS, 4, number of multiplexed digits; legal 1..8
- SCAN_DIV, 27000, clock cycles per digit slot; legal ≥ 2
- BLANK_CYCLES, 1, cycles at the start of each slot with anodes off (anti-ghosting); legal 0..SCAN_DIV-1
- SEG_ACTIVE_LOW, 1, 1 → seg/dp driven low-true
- AN_ACTIVE_LOW, 1, 1 → an driven low-true
- clk  in  1  system clock; the block's only clock
- rst_n  in  1  reset; synchronous, active-low
- data  in  4*NUM_DIGITS  hex nibbles; digit i = data[4i+3:4i], digit 0 least significant
- dp_in  in  NUM_DIGITS  decimal point per digit
- blank_in  in  NUM_DIGITS  1 → digit slot fully dark (anode never asserted)
- lz_en  in  1  leading-zero suppression enable (sampled with load)
- load  in  1  one-cycle strobe; captures data/dp_in/blank_in/lz_en
- seg  out  7  segments {g,f,e,d,c,b,a}
- dp  out  1  decimal point
- an  out  NUM_DIGITS  one-hot digit select
- frame_done  out  1  one-cycle pulse at each frame boundary

## Operation
- Decode (logical, active-high gfedcba): 0=0111111 1=0000110 2=1011011 3=1001111 4=1100110 5=1101101 6=1111101 7=0000111 8=1111111 9=1101111 A=1110111 b=1111100 C=0111001 d=1011110 E=1111001 F=1110001. Polarity is applied after decode.
- Prescaler cnt counts 0..SCAN_DIV-1 and wraps. Digit index idx increments when cnt = SCAN_DIV-1, scanning 0,1,…,NUM_DIGITS-1, then wrapping to 0.
- Two register sets: pending and active.
  - load writes pending and sets pend_valid. Multiple loads within a frame: last write wins.
  - Frame boundary = cycle where cnt = SCAN_DIV-1 and idx = NUM_DIGITS-1.
  - At the boundary, if pend_valid, pending is copied to active and pend_valid is cleared.
  - A load on the boundary cycle goes to pending only and applies at the next boundary.
- frame_done pulses at every boundary, whether or not an update occurred.
- Slot behaviour for idx = i:
  - an[i] is asserted only when cnt ≥ BLANK_CYCLES and active blank[i] = 0. All other an bits are deasserted.
  - With lz_en: digit i is suppressed if its nibble and every higher nibble are 0, and i ≠ 0. Digit 0 is never suppressed. A suppressed digit has seg = all off, dp = dp[i], and its anode still asserts.
  - dp = active dp[i] when the anode is asserted, otherwise off.
  - seg is off whenever the anode is deasserted.
- NUM_DIGITS = 1: idx is constant 0; every slot end is a frame boundary.

## Timing
- Reset (rst_n = 0 at a clk edge) clears cnt, idx, active, pending and pend_valid to 0. Next-cycle outputs are seg off, dp off, an all off, frame_done = 0. Applies identically mid-frame; a pending load is discarded.
- seg, dp, an and frame_done are registered: they reflect the (cnt, idx, active) state of the previous cycle, giving 1-cycle latency.
- Load-to-display latency is at most NUM_DIGITS·SCAN_DIV + 1 cycles. The newly active data first appears in slot 0.
- Frame period is exactly NUM_DIGITS·SCAN_DIV cycles. Each slot's lit time is SCAN_DIV − BLANK_CYCLES cycles.
- With BLANK_CYCLES = 0, the anode moves directly between adjacent digits on the same edge.

## Test plan
(SCAN_DIV = 4, BLANK_CYCLES = 1, NUM_DIGITS = 4, both polarities active-low unless stated.)
- Reset hold → seg = 1111111, dp = 1, an = 1111, frame_done = 0. Release reset: the first lit slot has an = 1110 for 3 cycles after 1 dark cycle.
- load data = 0x12AF, dp_in = 0100 → after the next frame_done: digit0 seg = 0001110 (F), digit1 = 0001000 (A), digit2 = 0100100 (2) with dp = 0, digit3 = 1111001 (1).
- data = 0x0070, lz_en = 1 → digits 3 and 2 are suppressed (seg = 1111111, an still asserted); digit1 = 7; digit0 = 0 is shown as 1000000.
- blank_in = 1000 → an[3] is never 0 across 3 frames; frame period stays 16 cycles; frame_done spacing is 16.
- Two loads in one frame (0x1111, then 0x2222) plus a load on the boundary cycle (0x3333) → the next frame shows 2222 and the following frame shows 3333. Reset mid-frame with a pending load → display returns to 0000 and the pending value is never shown.
- SEG_ACTIVE_LOW = 0, AN_ACTIVE_LOW = 0, data = 0x8888 → seg = 1111111 and one-hot active-high an during lit cycles; an = 0000 in blank cycles.
